// File: rtl/mul32_seq.sv
// Sequential 32x32 shift-add multiplier: 32 RUN iterations, one DONE cycle,
// registered 64-bit product split into hi/lo words with an overflow flag.
module mul32_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] prod_hi,
    output logic [31:0] prod_lo,
    output logic        ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Magnitude of an operand; 0x80000000 maps to itself as an unsigned value.
    function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic is_signed);
        logic [31:0] r;
        r = v;
        if (is_signed && (v < 0)) begin
            r = ~v + 32'd1;
        end
        return r;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] v);
        return ~v + 64'd1;
    endfunction

    function automatic logic calc_ovf(input logic [63:0] p, input logic is_signed);
        logic r;
        if (is_signed) begin
            r = (p[63:32] != {32{p[31]}});
        end else begin
            r = (p[63:32] != 32'd0);
        end
        return r;
    endfunction

    logic signed [31:0] op_a_s;
    logic signed [31:0] op_b_s;

    logic [1:0]  state_q,   state_d;
    logic [63:0] mcand_q,   mcand_d;
    logic [31:0] mplier_q,  mplier_d;
    logic [63:0] acc_q,     acc_d;
    logic [4:0]  cnt_q,     cnt_d;
    logic        sop_q,     sop_d;
    logic        neg_q,     neg_d;
    logic [31:0] prod_hi_q, prod_hi_d;
    logic [31:0] prod_lo_q, prod_lo_d;
    logic        ovf_q,     ovf_d;

    logic [63:0] acc_sum;
    logic [63:0] prod_full;

    assign op_a_s = op_a;
    assign op_b_s = op_b;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sop_d     = sop_q;
        neg_d     = neg_q;
        prod_hi_d = prod_hi_q;
        prod_lo_d = prod_lo_q;
        ovf_d     = ovf_q;

        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
        prod_full = neg_q ? neg64(acc_sum) : acc_sum;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sop_d    = signed_op;
                    neg_d    = signed_op & ((op_a_s < 0) ^ (op_b_s < 0));
                    mcand_d  = {32'd0, mag32(op_a_s, signed_op)};
                    mplier_d = mag32(op_b_s, signed_op);
                    acc_d    = 64'd0;
                    cnt_d    = 5'd0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                // Last iteration: publish the sign-corrected product directly.
                if (cnt_q == 5'd31) begin
                    state_d   = S_DONE;
                    prod_hi_d = prod_full[63:32];
                    prod_lo_d = prod_full[31:0];
                    ovf_d     = calc_ovf(prod_full, sop_q);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= 64'd0;
            mplier_q  <= 32'd0;
            acc_q     <= 64'd0;
            cnt_q     <= 5'd0;
            sop_q     <= 1'b0;
            neg_q     <= 1'b0;
            prod_hi_q <= 32'd0;
            prod_lo_q <= 32'd0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sop_q     <= sop_d;
            neg_q     <= neg_d;
            prod_hi_q <= prod_hi_d;
            prod_lo_q <= prod_lo_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign prod_hi = prod_hi_q;
    assign prod_lo = prod_lo_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mul32_seq.sv
// Directed bench for mul32_seq: latency, product/ovf values, busy rejection,
// reset abort and back-to-back operation.
module tb_mul32_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] prod_hi;
    logic [31:0] prod_lo;
    logic        ovf;

    int checks;
    int errors;

    mul32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a one-cycle start; returns #1 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        op_a      = a;
        op_b      = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'hDEAD_BEEF;
    endtask

    // Counts edges until done is seen, bounded.
    task automatic wait_done(inout int cyc);
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_case(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input logic exp_ovf);
        int cyc;
        issue(a, b, s);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_after_accept got %b want 1", name, busy);
        end
        cyc = 0;
        wait_done(cyc);
        checks++;
        if (done !== 1'b1 || cyc != 32) begin
            errors++;
            $display("FAIL %s_latency got done=%b cyc=%0d want done=1 cyc=32", name, done, cyc);
        end
        checks++;
        if (prod_hi !== exp_hi || prod_lo !== exp_lo || ovf !== exp_ovf) begin
            errors++;
            $display("FAIL %s_result got %h_%h ovf=%b want %h_%h ovf=%b",
                     name, prod_hi, prod_lo, ovf, exp_hi, exp_lo, exp_ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_after_done got busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || prod_hi !== 32'd0 || prod_lo !== 32'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b %h_%h ovf=%b want 0 0 0_0 0",
                     busy, done, prod_hi, prod_lo, ovf);
        end
    endtask

    task automatic test_unsigned();
        run_case("u_small", 32'd3, 32'd5, 1'b0, 32'h0000_0000, 32'h0000_000F, 1'b0);
        run_case("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    endtask

    task automatic test_signed();
        run_case("s_mixed", 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_case("s_zero", 32'hFFFF_FFFD, 32'd0, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run_case("s_extreme", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000, 1'b1);
        run_case("s_negneg", 32'hFFFF_FFFE, 32'hFFFF_FFFB, 1'b1, 32'h0000_0000, 32'h0000_000A, 1'b0);
    endtask

    task automatic test_busy_reject();
        int cyc;
        int extra;
        issue(32'd2, 32'd2, 1'b0);
        cyc = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(negedge clk);
        op_a  = 32'd9;
        op_b  = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        wait_done(cyc);
        checks++;
        if (done !== 1'b1 || cyc != 32) begin
            errors++;
            $display("FAIL busy_rej_latency got done=%b cyc=%0d want done=1 cyc=32", done, cyc);
        end
        checks++;
        if (prod_hi !== 32'd0 || prod_lo !== 32'd4 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL busy_rej_result got %h_%h ovf=%b want 0_4 ovf=0", prod_hi, prod_lo, ovf);
        end
        op_a  = 32'd9;
        op_b  = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        extra = 0;
        repeat (40) begin
            if (busy !== 1'b0 || done !== 1'b0) extra++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_rej_no_queue got %0d busy cycles want 0", extra);
        end
        checks++;
        if (prod_lo !== 32'd4) begin
            errors++;
            $display("FAIL busy_rej_hold got %h want 4", prod_lo);
        end
    endtask

    task automatic test_reset_abort();
        int seen;
        issue(32'd6, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || prod_hi !== 32'd0 || prod_lo !== 32'd0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort_state got busy=%b done=%b %h_%h ovf=%b want 0 0 0_0 0",
                     busy, done, prod_hi, prod_lo, ovf);
        end
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_abort_no_done got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int gap;
        issue(32'd6, 32'd7, 1'b0);
        cyc = 0;
        wait_done(cyc);
        checks++;
        if (done !== 1'b1 || prod_lo !== 32'd42 || prod_hi !== 32'd0) begin
            errors++;
            $display("FAIL b2b_first got done=%b %h_%h want 1 0_2a", done, prod_hi, prod_lo);
        end
        @(posedge clk);
        #1;
        gap = 1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap got busy=%b want 0", busy);
        end
        op_a      = 32'd2;
        op_b      = 32'd3;
        signed_op = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        gap++;
        start = 1'b0;
        cyc = 0;
        wait_done(cyc);
        gap += cyc;
        checks++;
        if (done !== 1'b1 || gap != 34) begin
            errors++;
            $display("FAIL b2b_spacing got done=%b gap=%0d want done=1 gap=34", done, gap);
        end
        checks++;
        if (prod_hi !== 32'd0 || prod_lo !== 32'd6 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second got %h_%h ovf=%b want 0_6 ovf=0", prod_hi, prod_lo, ovf);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_busy_reject();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul32_seq.md
# mul32_seq

Sequential 32x32 multiply unit for the SISC datapath. It accepts two 32-bit operands on a start pulse and runs an iterative shift-add over 32 cycles. It then presents the full 64-bit product as two 32-bit words, hi and lo. These words feed the 32-bit write-back mux, which selects one of them by its 2-bit select as the register-file write data.

## Interface
Parameters: none; widths fixed at 32-bit operands and 64-bit product.
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only while busy=0
- signed_op  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- op_a  input  32  multiplicand; sampled with start
- op_b  input  32  multiplier; sampled with start
- busy  output  1  high from the edge accepting start through the DONE cycle
- done  output  1  one-cycle pulse; result registers valid and updated
- prod_hi  output  32  product bits [63:32]
- prod_lo  output  32  product bits [31:0]
- ovf  output  1  product does not fit in 32 bits (see Operation)

## Operation
- State machine states: IDLE, RUN, DONE.
- IDLE with start=1:
  - capture signed_op and the sign flags of op_a and op_b.
  - If signed_op=1, load operand magnitudes (negate negative operands); otherwise load operands unchanged.
  - Clear the 64-bit accumulator and the 5-bit iteration counter. Go to RUN.
- IDLE with start=0: hold.
- RUN, each cycle:
  - if multiplier bit 0 = 1, add the shifted multiplicand into the accumulator.
  - Shift the multiplicand left 1 (64-bit) and the multiplier right 1. Increment the counter.
  - After the iteration with counter=31, go to DONE.
  - At that same edge, load prod_hi/prod_lo from the final accumulator, 64-bit negated when signed_op=1 and exactly one operand was negative. Compute ovf at the same edge.
- DONE: done=1, busy=1; next edge goes to IDLE unconditionally.
- ovf rules:
  - unsigned: ovf = (prod_hi != 0).
  - signed: ovf = (prod_hi != {32{prod_lo[31]}}).
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned 32-bit; no special case.
- A zero product is never negated to a nonzero value; 64-bit negation of 0 is 0.
- prod_hi, prod_lo and ovf hold their last completed values until the next DONE entry. start does not clear them.
- start while busy=1 (RUN or DONE) is ignored and not queued.
- Operand inputs are don't-care except in the cycle start is accepted.

## Timing
- Reset (rst=1 at a rising edge) forces:
  - state=IDLE, busy=0, done=0.
  - prod_hi=0, prod_lo=0, ovf=0.
  - internal accumulator and counter cleared.
- Reset mid-RUN or in DONE aborts the operation; no done pulse follows.
- Accept edge E0 (IDLE, start=1): busy=1 after E0.
- RUN occupies edges E1..E32; results and ovf update at E32.
- done=1 and busy=1 in the cycle after E32; both 0 after E33.
- Latency: done is visible 32 cycles after the accepting edge; throughput is one multiply per 34 cycles.
- Back-to-back: start may assert in the cycle after done (state IDLE) and is accepted at that edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned small: signed_op=0, op_a=3, op_b=5, start 1 cycle -> done exactly 32 cycles after the accept edge; prod_hi=0x00000000, prod_lo=0x0000000F, ovf=0; busy low one cycle after done.
- Unsigned max: op_a=op_b=0xFFFFFFFF, signed_op=0 -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001, ovf=1.
- Signed mixed: signed_op=1, op_a=0xFFFFFFFD (-3), op_b=7 -> prod_hi=0xFFFFFFFF, prod_lo=0xFFFFFFEB, ovf=0. Repeat with op_b=0 -> 0/0, ovf=0.
- Signed extreme: signed_op=1, op_a=op_b=0x80000000 -> prod_hi=0x40000000, prod_lo=0x00000000, ovf=1.
- Busy rejection: start accepted with 2x2; reassert start with 9x9 at RUN cycle 5 and during DONE -> single done, result 4; no second operation follows.
- Reset and back-to-back:
  - accept 6x7, assert rst at RUN cycle 10 -> busy=0, done never pulses, prod_hi=prod_lo=0, ovf=0.
  - then 6x7 followed by 2x3 started in the cycle after done -> done pulses 34 cycles apart; results 42 then 6.
